circ_sweep_ctrl: RTL and testbench
==================================

// Module: circ_sweep_ctrl
// PURPOSE
//  Exhaustive truth-table sequencer for a small N-input combinational gate-level circuit.
//  Drives every input vector onto the circuit under test, samples its single output F after a settle window,
//  compares F against a golden truth-table mask, and reports pass/fail, error count and first failing vector.
//  Sits between a test/host controller (start/abort handshake) and any circ_* gate-level block.
// PARAMETERS
//  N_IN      4         number of circuit inputs; vec_o[N_IN-1] is A (MSB), vec_o[0] is D (LSB)
//  SETTLE    1         extra cycles each vector is held before F is sampled (0..15)
//  EXP_MASK  16'hF830  golden truth table, width 2**N_IN; bit v = expected F for vec_o==v
//                      (default = A(CD+B)+BC')
// PORTS
//  clk              in   1          rising-edge clock
//  rst_n            in   1          asynchronous active-low reset
//  start            in   1          begin sweep; sampled only in IDLE
//  abort            in   1          cancel sweep; return to IDLE
//  f_i              in   1          F output of circuit under test
//  vec_o            out  N_IN       input vector driven to circuit (A..D)
//  busy             out  1          high in DRIVE state
//  done             out  1          1-cycle pulse when a sweep completes (not on abort)
//  pass             out  1          1 when last completed sweep had zero mismatches
//  err_cnt          out  N_IN+1     mismatch count of current/last sweep (max 2**N_IN, no saturation needed)
//  first_fail_vld   out  1          at least one mismatch seen in current/last sweep
//  first_fail_vec   out  N_IN       vec_o value of first mismatch; valid when first_fail_vld
// BEHAVIOUR
//  Reset: state=IDLE; vec_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vld=0, first_fail_vec=0.
//  FSM states: IDLE, DRIVE, DONE.
//  IDLE:  start=1 & abort=0 -> DRIVE; clear err_cnt, first_fail_vld, first_fail_vec, pass; step=0; settle_cnt=0.
//         start & abort same cycle -> abort wins, stay IDLE, results untouched.
//  DRIVE: vec_o = order(step), registered. Each vector held exactly SETTLE+1 cycles.
//         settle_cnt counts 0..SETTLE. f_i is sampled at the clock edge ending the cycle with settle_cnt==SETTLE.
//         Mismatch (f_i != EXP_MASK[vec_o]) -> err_cnt+1.
//         First mismatch also sets first_fail_vld=1 and first_fail_vec=vec_o.
//         step == 2**N_IN-1 at sample -> DONE; else step+1, settle_cnt=0 (vec_o updates next cycle).
//         start while busy is ignored.
//  DONE:  one cycle; done=1, pass=(err_cnt==0), busy=0, vec_o holds last vector; -> IDLE.
//  Latency: start sampled at edge k; done high during cycle k + 2**N_IN*(SETTLE+1) + 1.
//  abort in DRIVE: next cycle IDLE, busy=0, no done pulse, pass=0; err_cnt/first_fail_* keep partial values.
//  vec_o returns to 0 on entry to IDLE.
//  abort in DONE: ignored (done still pulses).
//  Async reset mid-sweep: immediate return to reset values; no done pulse.
//  step counter is N_IN+1 bits internally; no wrap-around of vec_o within a sweep.
//  A new start after DONE fully reruns the sweep.
// CONFIGURATION
//  CIRC_SWEEP_GRAY_EN defined:   order(step) = step ^ (step>>1) (Gray code, one input toggles per vector).
//                                EXP_MASK and first_fail_vec are still indexed by the vec_o value, not by step.
//  CIRC_SWEEP_GRAY_EN undefined: order(step) = step (binary 0..2**N_IN-1).
//  Latency, error counting and all other behaviour are identical in both builds.
// TESTING
//  1 Reset:      rst_n=0 mid-sweep at step 7 -> all outputs 0 within same cycle; no done after release.
//  2 Golden:     f_i from real circ_331a, SETTLE=1, start pulse ->
//                done at cycle k+33, pass=1, err_cnt=0, first_fail_vld=0; vec_o 0..15 in binary order.
//  3 Faulty:     circ_331a output forced 0 at vec 11 and 13 ->
//                pass=0, err_cnt=2, first_fail_vld=1, first_fail_vec=4'hB.
//  4 Abort:      abort asserted at step 5 ->
//                busy=0 next cycle, no done, pass=0, vec_o=0; later start gives full clean sweep.
//  5 Collisions: start&abort together in IDLE -> stays IDLE; start during busy -> no restart, done still at k+33.
//  6 Gray build: CIRC_SWEEP_GRAY_EN, SETTLE=0 ->
//                vec_o sequence 0,1,3,2,6,...,8 (one bit change per step), done at k+17, pass=1.

Source files
------------

// File: rtl/circ_sweep_ctrl.sv
// Exhaustive truth-table sequencer: drives every input vector, samples F after a settle window,
// and reports pass/fail, mismatch count and first failing vector. Define CIRC_SWEEP_GRAY_EN for Gray-code order.
module circ_sweep_ctrl #(
    parameter int unsigned            N_IN     = 4,
    parameter int unsigned            SETTLE   = 1,
    parameter logic [(1<<N_IN)-1:0]   EXP_MASK = 16'hF830
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            f_i,
    output logic [N_IN-1:0] vec_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_fail_vld,
    output logic [N_IN-1:0] first_fail_vec
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    localparam logic [N_IN:0] LAST_STEP = (N_IN+1)'((1 << N_IN) - 1);
    localparam logic [3:0]    SETTLE_L  = 4'(SETTLE);

    state_t          r_state;
    logic [N_IN:0]   r_step;
    logic [3:0]      r_settle;
    logic [N_IN-1:0] r_vec;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_err;
    logic            r_ff_vld;
    logic [N_IN-1:0] r_ff_vec;

    logic            w_mis;
    logic [N_IN:0]   w_err_nxt;

    function automatic logic [N_IN-1:0] order(input logic [N_IN-1:0] s);
`ifdef CIRC_SWEEP_GRAY_EN
        order = s ^ (s >> 1);
`else
        order = s;
`endif
    endfunction

    assign w_mis     = f_i ^ EXP_MASK[r_vec];
    assign w_err_nxt = r_err + {{N_IN{1'b0}}, w_mis};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_settle <= '0;
            r_vec    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_ff_vld <= 1'b0;
            r_ff_vec <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state  <= S_DRIVE;
                        r_busy   <= 1'b1;
                        r_step   <= '0;
                        r_settle <= '0;
                        r_vec    <= order('0);
                        r_err    <= '0;
                        r_ff_vld <= 1'b0;
                        r_ff_vec <= '0;
                        r_pass   <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_vec   <= '0;
                    end else if (r_settle == SETTLE_L) begin
                        r_err <= w_err_nxt;
                        if (w_mis && !r_ff_vld) begin
                            r_ff_vld <= 1'b1;
                            r_ff_vec <= r_vec;
                        end
                        if (r_step == LAST_STEP) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                        end else begin
                            // low bits never wrap here: the last step exits to DONE instead
                            r_step   <= r_step + 1'b1;
                            r_settle <= '0;
                            r_vec    <= order(r_step[N_IN-1:0] + 1'b1);
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_vec   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign vec_o          = r_vec;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_vec = r_ff_vec;

endmodule

// File: tb/tb_circ_sweep_ctrl.sv
// Self-checking bench for circ_sweep_ctrl: random fault masks, aborts, start collisions and reset,
// checked against a truth-table model of the sweep.
module tb_circ_sweep_ctrl;

    localparam int          N_IN     = 4;
    localparam int          SETTLE   = 1;
    localparam logic [15:0] EXP_MASK = 16'hF830;
    localparam int          NV       = 1 << N_IN;
    localparam int          CYC      = NV * (SETTLE + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            f_i;
    logic [N_IN-1:0] vec_o;
    logic            busy, done, pass, first_fail_vld;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_fail_vec;

    logic [NV-1:0]   fault = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // results the DUT should currently be holding
    int              m_err  = 0;
    logic            m_fv   = 1'b0;
    logic [3:0]      m_fvec = '0;
    logic            m_pass = 1'b0;

    always #5 clk = ~clk;

    circ_sweep_ctrl #(
        .N_IN    (N_IN),
        .SETTLE  (SETTLE),
        .EXP_MASK(EXP_MASK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .f_i           (f_i),
        .vec_o         (vec_o),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_cnt       (err_cnt),
        .first_fail_vld(first_fail_vld),
        .first_fail_vec(first_fail_vec)
    );

    // circuit under test: F = A(CD+B) + BC', with optional injected stuck faults
    function automatic logic circ_f(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (a & ((c & d) | b)) | (b & ~c);
    endfunction

    assign f_i = circ_f(vec_o) ^ fault[vec_o];

    function automatic logic [3:0] order(input int s);
`ifdef CIRC_SWEEP_GRAY_EN
        return 4'(s ^ (s / 2));
`else
        return 4'(s);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // outcome after the first nsteps vectors of the sweep order have been sampled
    task automatic model(input int nsteps);
        m_err = 0;
        m_fv  = 1'b0;
        m_fvec = '0;
        for (int s = 0; s < nsteps; s++) begin
            logic [3:0] v;
            v = order(s);
            if ((circ_f(v) ^ fault[v]) != EXP_MASK[v]) begin
                m_err++;
                if (!m_fv) begin
                    m_fv   = 1'b1;
                    m_fvec = v;
                end
            end
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_err"},   32'(err_cnt),        32'(m_err));
        check({tag, "_fvld"},  32'(first_fail_vld), 32'(m_fv));
        check({tag, "_fvec"},  32'(first_fail_vec), 32'(m_fvec));
        check({tag, "_pass"},  32'(pass),           32'(m_pass));
    endtask

    // ab_c / st_c / rs_c: drive-cycle index at which to abort, re-pulse start, or reset (-1 = never)
    task automatic sweep(input int ab_c, input int st_c, input int rs_c);
        int seen;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < CYC; c++) begin
            @(negedge clk);
            start = (c == st_c);
            abort = (c == ab_c);
            check("busy", 32'(busy), 32'd1);
            check("vec", 32'(vec_o), 32'(order(c / (SETTLE + 1))));
            check("no_early_done", 32'(done), 32'd0);
            if (c == rs_c) begin
                start = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                check("rst_vec",  32'(vec_o), 32'd0);
                check("rst_busy", 32'(busy),  32'd0);
                m_err = 0; m_fv = 1'b0; m_fvec = '0; m_pass = 1'b0;
                check_results("rst");
                @(negedge clk);
                rst_n = 1'b1;
                seen = 0;
                repeat (CYC + 4) begin
                    @(negedge clk);
                    if (done || busy) seen = 1;
                end
                check("rst_quiet", 32'(seen), 32'd0);
                return;
            end
            if (c == ab_c) begin
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", 32'(busy),  32'd0);
                check("abort_done", 32'(done),  32'd0);
                check("abort_vec",  32'(vec_o), 32'd0);
                model(c / (SETTLE + 1));
                m_pass = 1'b0;
                check_results("abort");
                seen = 0;
                repeat (CYC) begin
                    @(negedge clk);
                    if (done) seen = 1;
                end
                check("abort_no_done", 32'(seen), 32'd0);
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = ($urandom_range(0, 1) == 1);
        model(NV);
        m_pass = (m_err == 0);
        check("done_pulse", 32'(done),  32'd1);
        check("done_busy",  32'(busy),  32'd0);
        check("done_vec",   32'(vec_o), 32'(order(NV - 1)));
        check_results("done");
        @(negedge clk);
        abort = 1'b0;
        check("done_1cyc", 32'(done),  32'd0);
        check("idle_vec",  32'(vec_o), 32'd0);
        check_results("idle");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_vec",  32'(vec_o), 32'd0);
        check("reset_busy", 32'(busy),  32'd0);
        check("reset_done", 32'(done),  32'd0);
        check_results("reset");
        rst_n = 1'b1;
        @(negedge clk);

        fault = '0;
        sweep(-1, -1, -1);
        check("golden_pass", 32'(m_pass), 32'd1);

        fault = '0;
        fault[11] = 1'b1;
        fault[13] = 1'b1;
        sweep(-1, -1, -1);

        sweep(5 * (SETTLE + 1), -1, -1);
        fault = '0;
        sweep(-1, -1, -1);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("collide_busy", 32'(busy), 32'd0);
        check_results("collide");

        fault = 16'h0100;
        sweep(-1, 10, -1);
        sweep(-1, -1, 7 * (SETTLE + 1) + 1);

        for (int i = 0; i < 20; i++) begin
            int ab, st;
            fault = NV'($urandom);
            if ($urandom_range(0, 3) == 0) fault = '0;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, CYC - 1)) : -1;
            st = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, CYC - 2)) : -1;
            sweep(ab, st, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
